// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the datapath controller and seq_alu.
// master = controller side, slave = ALU side.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       czvn;

    modport master (
        output start, op, a, b, cin,
        input  ready, done, result, result_hi, czvn
    );

    modport slave (
        input  start, op, a, b, cin,
        output ready, done, result, result_hi, czvn
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multicycle ALU with registered result/flags {C,Z,V,N}.
// Define SEQ_ALU_MUL_EN to build the shift-add multiplier (op 7) and MUL_BUSY.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    localparam int W1 = WIDTH + 1;
    localparam int M  = WIDTH - 1;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic [3:0]       czvn_q;
    logic             done_q;

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [3:0]       alu_flags;
    logic             alu_go;

    always_comb begin
        add_w   = {1'b0, bus.a} + {1'b0, bus.b} + W1'(bus.cin);
        sub_w   = {1'b0, bus.a} - {1'b0, bus.b} - W1'(bus.cin);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.op)
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_ADD: begin
                alu_res = add_w[M:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (bus.a[M] == bus.b[M]) && (alu_res[M] != bus.a[M]);
            end
            OP_SUB: begin
                alu_res = sub_w[M:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (bus.a[M] != bus.b[M]) && (alu_res[M] != bus.a[M]);
            end
            OP_SHL: begin
                alu_res = {bus.a[M-1:0], 1'b0};
                alu_c   = bus.a[M];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.a[M:1]};
                alu_c   = bus.a[0];
            end
            default: alu_res = '0;
        endcase
        alu_flags = {alu_c, ~|alu_res, alu_v, alu_res[M]};
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd7;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [WIDTH-1:0]   mcand, mcand_nx;
    logic [WIDTH:0]     mul_sum;
    logic               mul_last;

    assign bus.ready = (state == IDLE);
    assign alu_go    = bus.start && (state == IDLE) && (bus.op != OP_MUL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            acc   <= acc_nx;
            mcand <= mcand_nx;
        end
    end

    // acc low half starts as the multiplier and shifts out one bit per step
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        mcand_nx = mcand;
        mul_last = 1'b0;
        mul_sum  = W1'(acc[2*WIDTH-1:WIDTH]) + W1'(acc[0] ? mcand : '0);
        unique case (state)
            IDLE: begin
                if (bus.start && bus.op == OP_MUL) begin
                    state_nx = MUL_BUSY;
                    cnt_nx   = '0;
                    acc_nx   = {{WIDTH{1'b0}}, bus.b};
                    mcand_nx = bus.a;
                end
            end
            MUL_BUSY: begin
                acc_nx = {mul_sum, acc[M:1]};
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(M)) begin
                    mul_last = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
`else
    assign bus.ready = 1'b1;
    assign alu_go    = bus.start;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            result_hi_q <= '0;
            czvn_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (alu_go) begin
                result_q    <= alu_res;
                result_hi_q <= '0;
                czvn_q      <= alu_flags;
                done_q      <= 1'b1;
            end
`ifdef SEQ_ALU_MUL_EN
            if (mul_last) begin
                result_q    <= acc_nx[M:0];
                result_hi_q <= acc_nx[2*WIDTH-1:WIDTH];
                czvn_q      <= {|acc_nx[2*WIDTH-1:WIDTH], ~|acc_nx,
                                1'b0, acc_nx[M]};
                done_q      <= 1'b1;
            end
`endif
        end
    end

    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.czvn      = czvn_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random and directed checks of seq_alu against an arithmetic model.
// Follows SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;
    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;

    logic [W-1:0] exp_res;
    logic [W-1:0] exp_hi;
    logic [3:0]   exp_flg;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    function automatic void model(input logic [2:0] o,
                                  input logic [W-1:0] x, y,
                                  input logic c,
                                  output logic [W-1:0] r, h,
                                  output logic [3:0] f);
        int  ia, ib, ic, s, ss, p;
        bit  cf, zf, vf;
        ia = int'(x);
        ib = int'(y);
        ic = int'(c);
        s  = 0;
        p  = 0;
        cf = 0;
        vf = 0;
        h  = '0;
        case (o)
            3'd0: s = ia & ib;
            3'd1: s = ia | ib;
            3'd2: begin
                s  = ia + ib + ic;
                cf = (s >= FULL);
                ss = sgn(ia) + sgn(ib) + ic;
                vf = (ss >= HALF) || (ss < -HALF);
            end
            3'd3: begin
                s  = ia - ib - ic;
                cf = (ia < ib + ic);
                ss = sgn(ia) - sgn(ib) - ic;
                vf = (ss >= HALF) || (ss < -HALF);
            end
            3'd4: s = ia ^ ib;
            3'd5: begin
                s  = ia * 2;
                cf = (ia >= HALF);
            end
            3'd6: begin
                s  = ia / 2;
                cf = (ia % 2 == 1);
            end
            default: begin
                if (MUL_ON) begin
                    p  = ia * ib;
                    s  = p % FULL;
                    h  = W'(p / FULL);
                    cf = (p / FULL != 0);
                end
            end
        endcase
        r  = W'(s & (FULL - 1));
        zf = (o == 3'd7 && MUL_ON) ? (p == 0) : (r == '0);
        f  = {cf, zf, vf, r[W-1]};
    endfunction

    // issue one op at posedge+1; returns in the cycle its done is expected
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, y,
                          input logic c, input bit poke);
        logic [W-1:0] r, h;
        logic [3:0]   f;
        int           lat;
        model(o, x, y, c, r, h, f);
        check("accept_ready", bus.ready, 1);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.cin   = c;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        lat = 1;
        while (!bus.done && lat < 4 * W) begin
            check("busy_ready", bus.ready, 0);
            check("busy_hold", bus.result, exp_res);
            if (poke && lat == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd2;
                bus.a     = W'(1);
                bus.b     = W'(1);
                bus.cin   = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        check("latency", lat, (MUL_ON && o == 3'd7) ? W + 1 : 1);
        check("done", bus.done, 1);
        check("ready", bus.ready, 1);
        check("result", bus.result, r);
        check("result_hi", bus.result_hi, h);
        check("czvn", bus.czvn, f);
        exp_res = r;
        exp_hi  = h;
        exp_flg = f;
    endtask

    task automatic idle_check();
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", bus.done, 0);
        check("idle_hold", {bus.result_hi, bus.result, bus.czvn},
              {exp_hi, exp_res, exp_flg});
    endtask

    task automatic check_reset_state(input string tag);
        check(tag, {bus.ready, bus.done, bus.result_hi, bus.result, bus.czvn},
              {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 4'h0});
    endtask

    initial begin
        vectors   = 0;
        errs      = 0;
        exp_res   = '0;
        exp_hi    = '0;
        exp_flg   = '0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        bus.start = 1'b1;
        bus.op    = 3'd1;
        bus.a     = 8'hFF;
        @(posedge clk);
        #1;
        check_reset_state("reset_over_start");
        bus.start = 1'b0;
        rst_n     = 1'b1;
        idle_check();

        run_op(3'd2, 8'hFF, 8'h01, 1'b0, 1'b0);
        check("add_ff_01", {bus.result, bus.czvn}, {8'h00, 4'b1100});
        run_op(3'd2, 8'h7F, 8'h01, 1'b0, 1'b0);
        check("add_7f_01", {bus.result, bus.czvn}, {8'h80, 4'b0011});
        run_op(3'd3, 8'h80, 8'h01, 1'b0, 1'b0);
        check("sub_80_01", {bus.result, bus.czvn}, {8'h7F, 4'b0010});
        run_op(3'd3, 8'h00, 8'h01, 1'b0, 1'b0);
        check("sub_00_01", {bus.result, bus.czvn}, {8'hFF, 4'b1001});
        run_op(3'd2, 8'h10, 8'h20, 1'b1, 1'b0);
        run_op(3'd3, 8'h10, 8'h0F, 1'b1, 1'b0);
        run_op(3'd4, 8'hA5, 8'hFF, 1'b0, 1'b0);
        check("xor", {bus.result, bus.czvn}, {8'h5A, 4'b0000});
        run_op(3'd6, 8'h81, 8'h00, 1'b0, 1'b0);
        idle_check();

        run_op(3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0);
        if (MUL_ON)
            check("mul_ff_ff", {bus.result_hi, bus.result, bus.czvn[3:2]},
                  {8'hFE, 8'h01, 2'b10});
        else
            check("op7_off", {bus.result_hi, bus.result, bus.czvn},
                  {8'h00, 8'h00, 4'b0100});
        run_op(3'd7, 8'h00, 8'h37, 1'b0, 1'b0);
        check("mul_zero_z", bus.czvn[2], 1);
        run_op(3'd7, 8'h0C, 8'h0B, 1'b0, MUL_ON);
        idle_check();

        // reset in the middle of an operation
        bus.start = 1'b1;
        bus.op    = MUL_ON ? 3'd7 : 3'd2;
        bus.a     = 8'hC3;
        bus.b     = 8'h5A;
        bus.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_state("mid_reset");
        exp_res = '0;
        exp_hi  = '0;
        exp_flg = '0;
        repeat (W + 2) idle_check();
        run_op(3'd5, 8'h81, 8'h00, 1'b0, 1'b0);
        check("shl_81", {bus.result, bus.czvn}, {8'h02, 4'b1000});

        for (int i = 0; i < 250; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            run_op(o, W'($urandom), W'($urandom), 1'($urandom),
                   MUL_ON && o == 3'd7 && $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                idle_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multicycle ALU for the datapath: registered result and flags, an eight-op set, and an iterative shift-add unsigned multiplier behind a start/ready/done handshake. The controller FSM issues one operation at a time and holds `start` until it sees `ready`. Results and flags are held until the next completion, so the controller can latch them at any point after `done`.

## Interface
- `WIDTH`, default 8: operand, result and result_hi width; must be ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only on an edge where `ready`=1.
- `op`  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- `a`, `b`  in  WIDTH  operands; sampled with `start`.
- `cin`  in  1  carry-in for ADD, borrow-in for SUB; ignored otherwise.
- `ready`  out  1  able to accept `start`.
- `done`  out  1  single-cycle pulse: new result and flags valid.
- `result`  out  WIDTH  low word.
- `result_hi`  out  WIDTH  MUL upper word; 0 for all other ops.
- `czvn`  out  4  registered flags {C, Z, V, N}.

## Operation
- States: IDLE and MUL_BUSY. Reset puts the block in IDLE.
- Reset values: `ready`=1, `done`=0, `result`=0, `result_hi`=0, `czvn`=0.
- Single-cycle ops (0–6), accepted in IDLE:
  - `result` and `czvn` register on the accepting edge; `done`=1 for the next cycle.
  - The block stays in IDLE.
- MUL, accepted in IDLE:
  - Latches `a` and `b` and goes to MUL_BUSY with an iteration counter at 0.
  - Each cycle does one shift-add step on a 2·WIDTH accumulator.
  - After WIDTH steps, writes {`result_hi`, `result`} = a·b (unsigned), pulses `done`, and returns to IDLE.
- Arithmetic, all unsigned at width WIDTH:
  - ADD = a+b+cin.
  - SUB = a−b−cin.
  - SHL = a<<1, SHR = a>>1 (logical). `b` is ignored for both.
- Flags:
  - C:
    - ADD: carry-out.
    - SUB: borrow, 1 when a < b+cin.
    - SHL: a[WIDTH-1]. SHR: a[0].
    - MUL: 1 when `result_hi`≠0.
    - Logic ops: 0.
  - Z: 1 when `result`==0; for MUL, when the full 2·WIDTH product is 0.
  - V: two's-complement overflow for ADD/SUB, otherwise 0.
  - N: `result`[WIDTH-1].
- Outputs not being updated hold their values; a new `start` does not clear them before completion.

## Timing
- Accept edge E0 = rising edge with `rst_n`=1, `ready`=1 and `start`=1.
- Ops 0–6: outputs valid and `done`=1 in the cycle after E0. `ready` stays 1, so back-to-back issue every cycle is allowed.
- MUL:
  - `ready`=0 from after E0 until the completion edge E0+WIDTH.
  - After E0+WIDTH: `done`=1 and `ready`=1 in the same cycle.
  - A new `start` is accepted on edge E0+WIDTH+1 at the earliest.
- `start` while `ready`=0 is ignored and is not queued. `a`, `b` and `op` may change freely during MUL_BUSY.
- `done` never stays high for two consecutive cycles unless two ops complete back-to-back.
- Reset mid-MUL: aborts the operation; there is no `done`, and all outputs return to reset values on that edge.
- Reset has priority over `start` on the same edge.

## Configuration
- `SEQ_ALU_MUL_EN` defined: op 7 is the iterative multiplier described above, and MUL_BUSY exists.
- `SEQ_ALU_MUL_EN` undefined:
  - No multiplier logic and no MUL_BUSY state; `ready` is tied to 1.
  - op 7 completes in one cycle with `result`=0, `result_hi`=0, `czvn`={0,1,0,0}.

## Test plan
- WIDTH=8, ADD a=8'hFF b=8'h01 cin=0 → next cycle `done`=1, `result`=8'h00, C=1 Z=1 V=0 N=0. Then ADD 8'h7F+8'h01 back-to-back → 8'h80, V=1 N=1 C=0.
- SUB a=8'h80 b=8'h01 cin=0 → 8'h7F, V=1 C=0. SUB a=8'h00 b=8'h01 → 8'hFF, C=1 N=1.
- MUL a=8'hFF b=8'hFF (macro on) → `ready`=0 for 8 cycles, then `done` with `result_hi`=8'hFE, `result`=8'h01, C=1 Z=0. MUL 8'h00×8'h37 → Z=1.
- During MUL_BUSY, pulse `start` with ADD 1+1 → ignored. Only the MUL `done` fires; outputs are not 8'h02.
- Assert `rst_n`=0 at MUL cycle 4 → no `done`, all outputs reset, `ready`=1. A fresh SHL a=8'h81 → `result`=8'h02, C=1.
- Macro off, WIDTH=16: op 7 → one-cycle `done`, `result`=16'h0000, Z=1. XOR 16'hA5A5^16'hFFFF → 16'h5A5A, C=0 V=0 N=0.
